stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CENTISECOND, default 250_000, clock cycles per 0.01 s tick; legal range >= 2.
REQ-002 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_Reset  input  1  reset, asynchronous, active-high.
REQ-004 i_Start_Stop  input  1  debounced single-cycle pulse, start/pause command.
REQ-005 i_Lap_Clear  input  1  debounced single-cycle pulse, lap/clear command.
REQ-006 i_Page  input  1  debounced single-cycle pulse, toggles displayed digit pair.
REQ-007 i_Time_BCD  input  16  live time from counter datapath: [15:8] seconds BCD, [7:0] centiseconds BCD.
REQ-008 o_Tick  output  1  single-cycle count enable to the counter datapath.
REQ-009 o_Clear  output  1  single-cycle synchronous clear to the counter datapath.
REQ-010 o_Digits  output  8  two BCD digits to the 7-segment encoders: [7:4] tens, [3:0] units.
REQ-011 o_State  output  2  current FSM state encoding.
REQ-012 o_Page  output  1  0 = seconds pair shown, 1 = centiseconds pair shown.

Function
REQ-013 FSM states: IDLE, RUN, PAUSE, LAP; a transition takes effect on the edge that samples the pulse.
REQ-014 IDLE: Start_Stop -> RUN; Lap_Clear -> stays IDLE and asserts o_Clear for 1 cycle.
REQ-015 RUN: Start_Stop -> PAUSE; Lap_Clear -> LAP, with i_Time_BCD captured into the lap register on the same edge.
REQ-016 LAP: Start_Stop -> PAUSE, releasing the freeze; Lap_Clear -> RUN, releasing the freeze.
REQ-017 PAUSE: Start_Stop -> RUN; Lap_Clear -> IDLE, with o_Clear asserted exactly 1 cycle, registered with the state change.
REQ-018 Start_Stop and Lap_Clear in the same cycle: Start_Stop wins; Lap_Clear is ignored, no capture, no clear.
REQ-019 Prescaler counts 0..CENTISECOND-1 only in RUN or LAP; it wraps to 0 after CENTISECOND-1.
REQ-020 o_Tick is high for exactly the cycle following the prescaler at CENTISECOND-1 (registered); period is exactly CENTISECOND cycles while running.
REQ-021 In PAUSE the prescaler holds its value, so the sub-tick fraction is preserved; it returns to 0 on entry to IDLE.
REQ-022 o_Tick is never asserted in IDLE or PAUSE, nor in the cycle o_Clear is asserted.
REQ-023 i_Page toggles o_Page in every state; i_Page is independent of the FSM and may coincide with other pulses.
REQ-024 Displayed source: the lap register in LAP, i_Time_BCD otherwise; o_Digits is the selected byte, registered with 1-cycle latency.
REQ-025 The block does no BCD arithmetic; wrap of the time value (59.99 -> 00.00) belongs to the datapath and is passed through unchanged.

Reset
REQ-026 Asserting i_Reset at any time, including mid-tick or in LAP, forces: state IDLE, prescaler 0, lap register 0x0000, o_Tick 0, o_Clear 0, o_Page 0, o_Digits 0x00.
REQ-027 After reset deasserts, the first run tick occurs exactly CENTISECOND cycles after entering RUN.

Structure
REQ-028 Shared package stopwatch_pkg holds the state encoding (IDLE=0, RUN=1, PAUSE=2, LAP=3) and the page constants.
REQ-029 Prescaler is a separate sub-module, stopwatch_prescaler (inputs enable and clear; output tick); the FSM, lap register and display mux stay in stopwatch_ctrl.

Verification (CENTISECOND=4)
REQ-030 Reset, then Start_Stop pulse -> o_State=RUN; o_Tick pulses every 4 cycles, first pulse 4 cycles after RUN entry.
REQ-031 Run 2 cycles into a tick, then Start_Stop twice 5 cycles apart -> no tick in PAUSE; the next tick comes 2 cycles after RUN re-entry.
REQ-032 In RUN with i_Time_BCD=0x1234, Lap_Clear, then drive i_Time_BCD=0x2000 -> o_Digits=0x12 (page 0) and 0x34 after i_Page; second Lap_Clear -> o_Digits=0x20.
REQ-033 PAUSE then Lap_Clear -> o_State=IDLE, o_Clear high exactly 1 cycle, o_Tick stays 0.
REQ-034 Start_Stop and Lap_Clear in the same cycle while in RUN -> PAUSE, no lap capture, o_Clear stays 0.
REQ-035 i_Reset asserted asynchronously mid-LAP -> all outputs at their reset values before the next clock edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding
// and the meaning of the display page bit.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Page 0 shows the seconds pair, page 1 the centiseconds pair.
  localparam logic PAGE_SECONDS = 1'b0;
  localparam logic PAGE_CENTIS  = 1'b1;

  // True for the states in which time is advancing.
  function automatic logic isRunning(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// Divides the system clock down to the 0.01 s count enable. The count only
// advances while enabled, so a pause keeps the sub-tick fraction intact.
module stopwatch_prescaler #(
  parameter int CENTISECOND = 250_000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CNT_W = (CENTISECOND > 2) ? $clog2(CENTISECOND) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CENTISECOND - 1);

  logic [CNT_W-1:0] r_Count;
  logic             r_Tick;

  // Count 0..CENTISECOND-1 while enabled and emit a registered tick on wrap;
  // clear wins so the fraction restarts from zero.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Count <= '0;
      r_Tick  <= 1'b0;
    end else if (i_Clear) begin
      r_Count <= '0;
      r_Tick  <= 1'b0;
    end else if (i_Enable) begin
      if (r_Count == LAST) begin
        r_Count <= '0;
        r_Tick  <= 1'b1;
      end else begin
        r_Count <= r_Count + CNT_W'(1);
        r_Tick  <= 1'b0;
      end
    end else begin
      r_Tick <= 1'b0;
    end
  end

  assign o_Tick = r_Tick;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/pause/lap/clear FSM, lap freeze register,
// display page select and the registered digit-pair mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CENTISECOND = 250_000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Start_Stop,
  input  logic        i_Lap_Clear,
  input  logic        i_Page,
  input  logic [15:0] i_Time_BCD,
  output logic        o_Tick,
  output logic        o_Clear,
  output logic [7:0]  o_Digits,
  output logic [1:0]  o_State,
  output logic        o_Page
);

  state_t      r_State;
  state_t      w_NextState;
  logic        w_Capture;
  logic        w_ClearNext;
  logic        w_PrescEnable;
  logic        w_PrescClear;
  logic [15:0] r_Lap;
  logic        r_Clear;
  logic        r_Page;
  logic [7:0]  r_Digits;
  logic [15:0] w_Source;
  logic [7:0]  w_Selected;

  // State register.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_State <= IDLE;
    else         r_State <= w_NextState;
  end

  // Next-state decode; Start_Stop takes priority so a simultaneous Lap_Clear
  // neither captures nor clears.
  always_comb begin
    w_NextState = r_State;
    w_Capture   = 1'b0;
    w_ClearNext = 1'b0;
    case (r_State)
      IDLE: begin
        if (i_Start_Stop)     w_NextState = RUN;
        else if (i_Lap_Clear) w_ClearNext = 1'b1;
      end
      RUN: begin
        if (i_Start_Stop) begin
          w_NextState = PAUSE;
        end else if (i_Lap_Clear) begin
          w_NextState = LAP;
          w_Capture   = 1'b1;
        end
      end
      LAP: begin
        if (i_Start_Stop)     w_NextState = PAUSE;
        else if (i_Lap_Clear) w_NextState = RUN;
      end
      PAUSE: begin
        if (i_Start_Stop) begin
          w_NextState = RUN;
        end else if (i_Lap_Clear) begin
          w_NextState = IDLE;
          w_ClearNext = 1'b1;
        end
      end
      default: w_NextState = IDLE;
    endcase
  end

  // The prescaler only advances on edges where time is running both before
  // and after, so the edge that pauses never produces a tick and the edge
  // that resumes does not count. Going to IDLE zeroes the fraction.
  assign w_PrescEnable = isRunning(r_State) && isRunning(w_NextState);
  assign w_PrescClear  = (w_NextState == IDLE);

  stopwatch_prescaler #(
    .CENTISECOND(CENTISECOND)
  ) u_prescaler (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Enable(w_PrescEnable),
    .i_Clear (w_PrescClear),
    .o_Tick  (o_Tick)
  );

  // Lap register freezes the live time on entry to LAP.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)        r_Lap <= 16'h0000;
    else if (w_Capture) r_Lap <= i_Time_BCD;
  end

  // Single-cycle datapath clear, registered alongside the state change.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_Clear <= 1'b0;
    else         r_Clear <= w_ClearNext;
  end

  // Page toggle runs independently of the FSM.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_Page <= PAGE_SECONDS;
    else         r_Page <= r_Page ^ i_Page;
  end

  assign w_Source   = (r_State == LAP) ? r_Lap : i_Time_BCD;
  assign w_Selected = (r_Page == PAGE_CENTIS) ? w_Source[7:0] : w_Source[15:8];

  // Registered digit pair for the segment encoders.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_Digits <= 8'h00;
    else         r_Digits <= w_Selected;
  end

  assign o_Clear  = r_Clear;
  assign o_Page   = r_Page;
  assign o_Digits = r_Digits;
  assign o_State  = r_State;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle centisecond.
module tb_stopwatch_ctrl;

  logic        i_Clk;
  logic        i_Reset;
  logic        i_Start_Stop;
  logic        i_Lap_Clear;
  logic        i_Page;
  logic [15:0] i_Time_BCD;
  logic        o_Tick;
  logic        o_Clear;
  logic [7:0]  o_Digits;
  logic [1:0]  o_State;
  logic        o_Page;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CENTISECOND(4)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Start_Stop(i_Start_Stop),
    .i_Lap_Clear (i_Lap_Clear),
    .i_Page      (i_Page),
    .i_Time_BCD  (i_Time_BCD),
    .o_Tick      (o_Tick),
    .o_Clear     (o_Clear),
    .o_Digits    (o_Digits),
    .o_State     (o_State),
    .o_Page      (o_Page)
  );

  // Free-running 10 ns clock.
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Advance one rising edge and settle 1 ns past it.
  task automatic tickClock();
    @(posedge i_Clk);
    #1;
  endtask

  // Drive single-cycle pulses across exactly one rising edge.
  task automatic applyStimulus(input logic ss, input logic lc, input logic pg);
    i_Start_Stop = ss;
    i_Lap_Clear  = lc;
    i_Page       = pg;
    tickClock();
    i_Start_Stop = 1'b0;
    i_Lap_Clear  = 1'b0;
    i_Page       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_state"},  16'(o_State),  16'h0);
    checkOutput({tag, "_tick"},   16'(o_Tick),   16'h0);
    checkOutput({tag, "_clear"},  16'(o_Clear),  16'h0);
    checkOutput({tag, "_page"},   16'(o_Page),   16'h0);
    checkOutput({tag, "_digits"}, 16'(o_Digits), 16'h0);
  endtask

  // Directed sequence.
  initial begin
    i_Reset      = 1'b1;
    i_Start_Stop = 1'b0;
    i_Lap_Clear  = 1'b0;
    i_Page       = 1'b0;
    i_Time_BCD   = 16'h0000;
    tickClock();
    tickClock();
    checkAllReset("reset");
    i_Reset = 1'b0;
    tickClock();
    checkOutput("idle_state", 16'(o_State), 16'h0);

    $display("[TB] start and free-running ticks");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_state", 16'(o_State), 16'h1);
    checkOutput("run_entry_tick", 16'(o_Tick), 16'h0);
    for (int k = 1; k <= 8; k++) begin
      tickClock();
      checkOutput($sformatf("run_tick_%0d", k), 16'(o_Tick), (k % 4 == 0) ? 16'h1 : 16'h0);
    end

    $display("[TB] pause preserves fraction");
    tickClock();
    checkOutput("pre_pause_tick_a", 16'(o_Tick), 16'h0);
    tickClock();
    checkOutput("pre_pause_tick_b", 16'(o_Tick), 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pause_state", 16'(o_State), 16'h2);
    checkOutput("pause_entry_tick", 16'(o_Tick), 16'h0);
    for (int k = 1; k <= 4; k++) begin
      tickClock();
      checkOutput($sformatf("pause_tick_%0d", k), 16'(o_Tick), 16'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", 16'(o_State), 16'h1);
    checkOutput("resume_tick_0", 16'(o_Tick), 16'h0);
    tickClock();
    checkOutput("resume_tick_1", 16'(o_Tick), 16'h0);
    tickClock();
    checkOutput("resume_tick_2", 16'(o_Tick), 16'h1);

    $display("[TB] lap freeze and paging");
    i_Time_BCD = 16'h1234;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap_state", 16'(o_State), 16'h3);
    checkOutput("lap_entry_digits", 16'(o_Digits), 16'h12);
    i_Time_BCD = 16'h2000;
    tickClock();
    checkOutput("lap_frozen_sec", 16'(o_Digits), 16'h12);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("page_to_1", 16'(o_Page), 16'h1);
    tickClock();
    checkOutput("lap_frozen_centi", 16'(o_Digits), 16'h34);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("page_to_0", 16'(o_Page), 16'h0);
    tickClock();
    checkOutput("lap_frozen_sec_again", 16'(o_Digits), 16'h12);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap_release_state", 16'(o_State), 16'h1);
    tickClock();
    checkOutput("live_digits", 16'(o_Digits), 16'h20);

    $display("[TB] simultaneous start_stop and lap_clear");
    i_Time_BCD = 16'h5678;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_state", 16'(o_State), 16'h2);
    checkOutput("both_clear", 16'(o_Clear), 16'h0);
    tickClock();
    checkOutput("both_clear_after", 16'(o_Clear), 16'h0);
    checkOutput("both_digits", 16'(o_Digits), 16'h56);
    checkOutput("both_tick", 16'(o_Tick), 16'h0);

    $display("[TB] clear from pause and idle");
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clr_state", 16'(o_State), 16'h0);
    checkOutput("clr_pulse", 16'(o_Clear), 16'h1);
    checkOutput("clr_tick", 16'(o_Tick), 16'h0);
    tickClock();
    checkOutput("clr_pulse_end", 16'(o_Clear), 16'h0);
    checkOutput("clr_tick_after", 16'(o_Tick), 16'h0);
    checkOutput("clr_state_after", 16'(o_State), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("idle_clr_state", 16'(o_State), 16'h0);
    checkOutput("idle_clr_pulse", 16'(o_Clear), 16'h1);
    tickClock();
    checkOutput("idle_clr_end", 16'(o_Clear), 16'h0);

    $display("[TB] restart from idle starts a fresh fraction");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tickClock();
      checkOutput($sformatf("fresh_tick_%0d", k), 16'(o_Tick), (k == 4) ? 16'h1 : 16'h0);
    end

    $display("[TB] asynchronous reset in lap");
    i_Time_BCD = 16'h4321;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tickClock();
    checkOutput("pre_reset_state", 16'(o_State), 16'h3);
    checkOutput("pre_reset_digits", 16'(o_Digits), 16'h21);
    #2;
    i_Reset = 1'b1;
    #1;
    checkAllReset("async_reset");
    #3;
    i_Reset = 1'b0;
    tickClock();
    checkOutput("post_reset_state", 16'(o_State), 16'h0);
    checkOutput("post_reset_digits", 16'(o_Digits), 16'h43);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tickClock();
      checkOutput($sformatf("post_reset_tick_%0d", k), 16'(o_Tick), (k == 4) ? 16'h1 : 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
